// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake motion controller.
package snake_pkg;

    localparam int MAX_LEN = 256;

    typedef logic [7:0] pos_t;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_MOVE  = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    function automatic logic is_reverse(dir_t a, dir_t b);
        return ((a == UP)    && (b == DOWN))  ||
               ((a == DOWN)  && (b == UP))    ||
               ((a == LEFT)  && (b == RIGHT)) ||
               ((a == RIGHT) && (b == LEFT));
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head computation on a 16x16 grid.
// Edge crossings are wall hits unless WRAP folds them modulo 16.
module snake_next_head
    import snake_pkg::*;
#(
    parameter bit WRAP = 1'b0
) (
    input  pos_t i_head,
    input  dir_t i_dir,
    output pos_t o_nh,
    output logic o_wall_hit
);

    logic [3:0] w_row;
    logic [3:0] w_col;
    logic       w_edge;

    always_comb begin
        w_row  = i_head[7:4];
        w_col  = i_head[3:0];
        w_edge = 1'b0;
        unique case (i_dir)
            UP: begin
                w_edge = (i_head[7:4] == 4'h0);
                w_row  = i_head[7:4] - 4'd1;
            end
            DOWN: begin
                w_edge = (i_head[7:4] == 4'hF);
                w_row  = i_head[7:4] + 4'd1;
            end
            LEFT: begin
                w_edge = (i_head[3:0] == 4'h0);
                w_col  = i_head[3:0] - 4'd1;
            end
            RIGHT: begin
                w_edge = (i_head[3:0] == 4'hF);
                w_col  = i_head[3:0] + 4'd1;
            end
            default: ;
        endcase
    end

    assign o_nh       = {w_row, w_col};
    assign o_wall_hit = !WRAP && w_edge;

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake motion sequencer: next head, serial self-collision scan,
// then a one-cycle body shift with optional growth.
module snake_move_ctrl
    import snake_pkg::*;
#(
    parameter int   MAX_LEN   = snake_pkg::MAX_LEN,
    parameter int   INIT_LEN  = 3,
    parameter pos_t INIT_HEAD = 8'h88,
    parameter bit   WRAP      = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     step,
    input  logic [1:0]               dir,
    input  logic [7:0]               food_pos,
    input  logic                     restart,
    output logic [MAX_LEN-1:0][7:0]  pos,
    output logic [7:0]               length,
    output logic                     busy,
    output logic                     ate,
    output logic                     game_over
);

    typedef pos_t [MAX_LEN-1:0] body_t;

    function automatic body_t init_body();
        body_t b;
        for (int i = 0; i < MAX_LEN; i++) begin
            b[i] = (i < INIT_LEN) ? pos_t'(INIT_HEAD - pos_t'(i)) : '0;
        end
        return b;
    endfunction

    localparam body_t      INIT_BODY = init_body();
    localparam logic [8:0] LEN_INIT  = 9'(INIT_LEN);
    localparam logic [8:0] LEN_MAX   = 9'(MAX_LEN);

    state_t     r_state;
    dir_t       r_dir;
    body_t      r_pos;
    logic [8:0] r_len;
    pos_t       r_nh;
    logic       r_grow;
    logic [7:0] r_k;
    logic [7:0] r_last;
    logic       r_busy;
    logic       r_ate;
    logic       r_over;

    dir_t       w_req;
    dir_t       w_dir;
    pos_t       w_nh;
    logic       w_wall;
    logic       w_grow;
    logic       w_full;
    logic [7:0] w_lim;
    logic       w_hit;

    assign w_req  = dir_t'(dir);
    assign w_dir  = is_reverse(w_req, r_dir) ? r_dir : w_req;
    assign w_grow = (w_nh == food_pos);
    assign w_full = (r_len == LEN_MAX);
    // Scan limit: tail cell vacates unless we grow (and can grow).
    assign w_lim  = (w_grow && !w_full) ? r_len[7:0] : r_len[7:0] - 8'd1;
    assign w_hit  = (r_pos[r_k] == r_nh);

    snake_next_head #(
        .WRAP(WRAP)
    ) u_next_head (
        .i_head    (r_pos[0]),
        .i_dir     (w_dir),
        .o_nh      (w_nh),
        .o_wall_hit(w_wall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_dir   <= RIGHT;
            r_pos   <= INIT_BODY;
            r_len   <= LEN_INIT;
            r_nh    <= '0;
            r_grow  <= 1'b0;
            r_k     <= '0;
            r_last  <= '0;
            r_busy  <= 1'b0;
            r_ate   <= 1'b0;
            r_over  <= 1'b0;
        end else if (restart) begin
            r_state <= S_IDLE;
            r_dir   <= RIGHT;
            r_pos   <= INIT_BODY;
            r_len   <= LEN_INIT;
            r_nh    <= '0;
            r_grow  <= 1'b0;
            r_k     <= '0;
            r_last  <= '0;
            r_busy  <= 1'b0;
            r_ate   <= 1'b0;
            r_over  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_ate <= 1'b0;
                    if (step) begin
                        r_dir  <= w_dir;
                        r_nh   <= w_nh;
                        r_grow <= w_grow;
                        r_k    <= '0;
                        r_last <= w_lim - 8'd1;
                        if (w_wall) begin
                            r_state <= S_DEAD;
                            r_over  <= 1'b1;
                        end else if (w_lim == 8'd0) begin
                            r_state <= S_MOVE;
                            r_busy  <= 1'b1;
                            r_ate   <= w_grow;
                        end else begin
                            r_state <= S_CHECK;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_hit) begin
                        r_state <= S_DEAD;
                        r_busy  <= 1'b0;
                        r_over  <= 1'b1;
                    end else if (r_k == r_last) begin
                        r_state <= S_MOVE;
                        r_ate   <= r_grow;
                    end else begin
                        r_k <= r_k + 8'd1;
                    end
                end
                S_MOVE: begin
                    r_pos   <= {r_pos[MAX_LEN-2:0], r_nh};
                    if (r_grow && !w_full) begin
                        r_len <= r_len + 9'd1;
                    end
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ate   <= 1'b0;
                end
                S_DEAD: begin
                    r_busy <= 1'b0;
                    r_ate  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pos       = r_pos;
    assign length    = r_len[7:0];
    assign busy      = r_busy;
    assign ate       = r_ate;
    assign game_over = r_over;

endmodule
